bin_avg_stream: RTL and testbench

Next-generation FFT bin averager for the binning datapath, replacing the fixed wrapper around the N-bin averager. Accepts BINS signed bins per frame, accumulates them over 2^n_avgs frames (runtime-selectable, clamped to what SUM_WIDTH allows), and emits either the mean or the saturated raw sum at N_OUT bits per bin. Adds what the previous block lacked: a ready/valid output handshake, a per-block mode select, and a sticky overrun flag for dropped results.

---
 rtl/bin_avg_pkg.sv | 17 +
 rtl/bin_accumulator.sv | 33 +++
 rtl/bin_avg_stream.sv | 79 +++++++
 tb/tb_bin_avg_stream.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/bin_avg_pkg.sv
// bin_avg_pkg: shared mode type and sizing/saturation helpers for the bin averager
package bin_avg_pkg;
  typedef enum logic {MODE_MEAN = 1'b0, MODE_SUM = 1'b1} avg_mode_t;
  function automatic int max_avgs(input int sum_width, input int n);
    return sum_width - n;
  endfunction
  function automatic logic [7:0] clamp_avgs(input logic [7:0] req, input int max_n);
    return (int'(req) > max_n) ? 8'(max_n) : req;
  endfunction
  // clamp a sign-extended accumulator value into a w-bit signed range
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return (v > hi) ? hi : (v < lo) ? lo : v;
  endfunction
endpackage

// File: rtl/bin_accumulator.sv
// bin_accumulator: one bin lane -- accumulate, final add, then mean-scale or saturate
module bin_accumulator
  import bin_avg_pkg::*;
#(
  parameter int N = 16,
  parameter int N_OUT = 8,
  parameter int SUM_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    arest_n,
  input  logic                    in_valid,
  input  logic                    last,
  input  logic signed [N-1:0]     din,
  input  logic [7:0]              shift,
  input  avg_mode_t               mode,
  output logic signed [N_OUT-1:0] result
);
  logic signed [SUM_WIDTH-1:0] acc, fin, sum, mean;
  logic signed [63:0] wide, clipped;
  assign sum = acc + SUM_WIDTH'(din);
  assign mean = fin >>> shift;
  assign wide = 64'(fin);
  assign clipped = sat(wide, N_OUT);
  assign result = (mode == MODE_SUM) ? clipped[N_OUT-1:0] : mean[N-1 -: N_OUT];
  always_ff @(posedge clk or negedge arest_n)
    if (!arest_n) begin
      acc <= '0;
      fin <= '0;
    end else if (in_valid) begin
      acc <= last ? '0 : sum;
      if (last) fin <= sum;
    end
endmodule

// File: rtl/bin_avg_stream.sv
// bin_avg_stream: averages BINS parallel signed bins over 2^n frames with a ready/valid result
// register and a sticky overrun flag for results that find the register occupied.
module bin_avg_stream
  import bin_avg_pkg::*;
#(
  parameter int N = 16,
  parameter int N_OUT = 8,
  parameter int SUM_WIDTH = 32,
  parameter int BINS = 4
) (
  input  logic                    clk,
  input  logic                    arest_n,
  input  logic                    in_valid,
  input  logic [BINS*N-1:0]       in_data,
  input  logic [7:0]              n_avgs_in,
  input  logic                    mode_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BINS*N_OUT-1:0]   out_data,
  output logic [7:0]              frame_cnt,
  output logic                    overrun,
  input  logic                    clr_overrun
);
  localparam int MAX_AVGS = max_avgs(SUM_WIDTH, N);
  localparam int CW = MAX_AVGS;
  logic [CW-1:0] cnt;
  logic [7:0] n_eff, n_cur, fin_n;
  avg_mode_t mode, mode_cur, fin_mode;
  logic done, last, start, load;
  logic [BINS*N_OUT-1:0] results;
  assign start = in_valid && cnt == '0;
  assign n_cur = start ? clamp_avgs(n_avgs_in, MAX_AVGS) : n_eff;
  assign mode_cur = start ? avg_mode_t'(mode_in) : mode;
  assign last = in_valid && cnt == CW'((64'd1 << n_cur) - 64'd1);
  assign load = done && (!out_valid || out_ready);
  assign frame_cnt = 8'(cnt);
  // block parameters travel with the finished sum so a block starting on the
  // very next edge cannot alter how the previous result is scaled
  always_ff @(posedge clk or negedge arest_n)
    if (!arest_n) begin
      cnt <= '0;
      n_eff <= '0;
      mode <= MODE_MEAN;
      fin_n <= '0;
      fin_mode <= MODE_MEAN;
      done <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      overrun <= 1'b0;
    end else begin
      if (in_valid) cnt <= last ? '0 : cnt + 1'b1;
      if (start) begin
        n_eff <= n_cur;
        mode <= mode_cur;
      end
      if (last) begin
        fin_n <= n_cur;
        fin_mode <= mode_cur;
      end
      done <= last;
      if (load) begin
        out_data <= results;
        out_valid <= 1'b1;
      end else if (out_ready) out_valid <= 1'b0;
      overrun <= (done && !load) ? 1'b1 : clr_overrun ? 1'b0 : overrun;
    end
  for (genvar b = 0; b < BINS; b++) begin : g_lane
    bin_accumulator #(.N(N), .N_OUT(N_OUT), .SUM_WIDTH(SUM_WIDTH)) u_lane (
      .clk(clk),
      .arest_n(arest_n),
      .in_valid(in_valid),
      .last(last),
      .din(in_data[b*N +: N]),
      .shift(fin_n),
      .mode(fin_mode),
      .result(results[b*N_OUT +: N_OUT])
    );
  end
endmodule

// File: tb/tb_bin_avg_stream.sv
// tb_bin_avg_stream: directed vectors with hand-computed results for bin_avg_stream
module tb_bin_avg_stream;
  logic clk = 0, arest_n = 0, in_valid = 0, mode_in = 0, out_ready = 0, clr_overrun = 0;
  logic [63:0] in_data = '0;
  logic [7:0] n_avgs_in = '0, frame_cnt;
  logic out_valid, overrun;
  logic [31:0] out_data;
  int checks = 0, errors = 0;

  bin_avg_stream dut (
    .clk(clk), .arest_n(arest_n), .in_valid(in_valid), .in_data(in_data),
    .n_avgs_in(n_avgs_in), .mode_in(mode_in), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .frame_cnt(frame_cnt),
    .overrun(overrun), .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] b0, b1, b2, b3);
    in_data = {b3, b2, b1, b0};
    in_valid = 1;
    tick;
    in_valid = 0;
  endtask

  initial begin
    #1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", out_data, 0);
    check("rst_cnt", 32'(frame_cnt), 0);
    check("rst_ovr", 32'(overrun), 0);
    tick;
    arest_n = 1;
    out_ready = 1;
    tick;

    // mean over 4 frames
    n_avgs_in = 2;
    mode_in = 0;
    send(100, -16'sd100, 0, 16'h4000);
    check("mean_cnt1", 32'(frame_cnt), 1);
    send(200, -16'sd100, 0, 16'h4000);
    send(300, -16'sd100, 0, 16'h4000);
    send(400, -16'sd100, 0, 16'h4000);
    check("mean_lat", 32'(out_valid), 0);
    tick;
    check("mean_valid", 32'(out_valid), 1);
    check("mean_data", out_data, 32'h4000FF00);
    tick;
    check("mean_accept", 32'(out_valid), 0);
    send(6400, -16'sd1, 0, 0);
    send(12800, -16'sd1, 0, 0);
    send(19200, -16'sd1, 0, 0);
    send(25600, -16'sd1, 0, 0);
    tick;
    check("mean_scaled", out_data, 32'h0000FF3E);

    // raw sum, one result per frame
    n_avgs_in = 0;
    mode_in = 1;
    tick;
    send(100, 16'h7FFF, 0, 0);
    send(0, 16'h8000, 0, 0);
    check("sum_pos", out_data, 32'h00007F64);
    send(0, 5, 0, 0);
    check("sum_neg", out_data, 32'h00008000);
    tick;
    check("sum_small", out_data, 32'h00000500);
    check("sum_valid", 32'(out_valid), 1);
    tick;

    // back-pressure and overrun
    out_ready = 0;
    send(3, 0, 0, 0);
    send(7, 0, 0, 0);
    check("bp_hold_v", 32'(out_valid), 1);
    check("bp_first", out_data, 32'h00000003);
    tick;
    check("bp_ovr", 32'(overrun), 1);
    check("bp_keep", out_data, 32'h00000003);
    send(9, 0, 0, 0);
    clr_overrun = 1;
    tick;
    check("ovr_set_wins", 32'(overrun), 1);
    tick;
    check("ovr_clear", 32'(overrun), 0);
    clr_overrun = 0;
    out_ready = 1;
    tick;
    check("bp_release", 32'(out_valid), 0);
    check("bp_old_data", out_data, 32'h00000003);

    // mid-block n_avgs change is ignored
    mode_in = 0;
    n_avgs_in = 1;
    send(16'h1000, 0, 0, 0);
    n_avgs_in = 3;
    check("mid_cnt", 32'(frame_cnt), 1);
    send(16'h3000, 0, 0, 0);
    check("mid_wrap", 32'(frame_cnt), 0);
    tick;
    check("mid_valid", 32'(out_valid), 1);
    check("mid_data", out_data, 32'h00000020);
    for (int i = 0; i < 7; i++) send(16'h0800, 0, 0, 0);
    check("blk8_cnt", 32'(frame_cnt), 7);
    check("blk8_pending", 32'(out_valid), 0);
    send(16'h0800, 0, 0, 0);
    tick;
    check("blk8_valid", 32'(out_valid), 1);
    check("blk8_data", out_data, 32'h00000008);
    tick;

    // reset mid-block discards the partial sum
    n_avgs_in = 2;
    for (int i = 0; i < 3; i++) send(16'h7000, 0, 0, 0);
    arest_n = 0;
    #1;
    check("rst_mid_cnt", 32'(frame_cnt), 0);
    check("rst_mid_valid", 32'(out_valid), 0);
    tick;
    arest_n = 1;
    for (int i = 0; i < 4; i++) send(16'h0400, 0, 0, 0);
    tick;
    check("post_rst_valid", 32'(out_valid), 1);
    check("post_rst_data", out_data, 32'h00000004);
    tick;

    // n_avgs clamps to 16: 65536 frames per block
    n_avgs_in = 200;
    for (int i = 0; i < 65535; i++) send(16'h0100, 16'hFFFF, 0, 0);
    check("clamp_cnt", 32'(frame_cnt), 32'hFF);
    n_avgs_in = 0;
    tick;
    check("clamp_pending", 32'(out_valid), 0);
    send(16'h0100, 16'hFFFF, 0, 0);
    tick;
    check("clamp_valid", 32'(out_valid), 1);
    check("clamp_data", out_data, 32'h0000FF01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
